// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot/periodic terminal-count pulse
//   clock       rising-edge clock
//   resetn      asynchronous active-low reset
//   load_valid  load request, load_value valid while high
//   load_value  start/reload value
//   load_ready  load can be accepted this cycle (combinational)
//   enable      count enable, low holds the count
//   auto_reload 1 = periodic, 0 = one-shot, sampled at the terminal edge
//   abort       synchronous stop/clear
//   count_out   current count (registered)
//   busy        timer running
//   done        timer expired (one-shot or zero load)
//   tc_pulse    registered one-cycle terminal-count pulse
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             enable,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] count_n, reload, reload_n;
    logic             tc_n, load_acc, terminal;
    assign load_ready = (state != RUN) && !abort;
    assign load_acc   = load_valid && load_ready;
    assign terminal   = (state == RUN) && enable && (count_out == WIDTH'(1));
    assign busy       = state == RUN;
    assign done       = state == DONE;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            count_out <= '0;
            reload    <= '0;
            tc_pulse  <= 1'b0;
        end else begin
            state     <= state_n;
            count_out <= count_n;
            reload    <= reload_n;
            tc_pulse  <= tc_n;
        end
    end
    // Priority: abort, then load, then counting. RUN always holds a nonzero
    // count, so the decrement never goes below zero.
    always_comb begin
        state_n  = state;
        count_n  = count_out;
        reload_n = reload;
        tc_n     = 1'b0;
        if (abort) begin
            state_n = IDLE;
            count_n = '0;
        end else if (load_acc) begin
            reload_n = load_value;
            count_n  = load_value;
            state_n  = (load_value != '0) ? RUN : DONE;
            tc_n     = load_value == '0;
        end else if (terminal) begin
            tc_n    = 1'b1;
            count_n = auto_reload ? reload : '0;
            state_n = auto_reload ? RUN : DONE;
        end else if (state == RUN && enable) begin
            count_n = count_out - WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: self-checking bench for down_timer with directed and random stimulus
module tb_down_timer;
    logic       clock = 0;
    logic       resetn = 0;
    logic       lv = 0, en = 0, ar = 0, ab = 0;
    logic [7:0] lval = 0;
    logic       load_ready, busy, done, tc_pulse;
    logic [7:0] count_out;
    int         total = 0, bad = 0;
    int         m_state = 0;
    logic [7:0] m_count = 0, m_reload = 0;
    logic       m_tc = 0;

    down_timer #(.WIDTH(8)) dut (
        .clock(clock), .resetn(resetn), .load_valid(lv), .load_value(lval),
        .load_ready(load_ready), .enable(en), .auto_reload(ar), .abort(ab),
        .count_out(count_out), .busy(busy), .done(done), .tc_pulse(tc_pulse)
    );

    always #5 clock = ~clock;

    // m_state: 0 idle, 1 running, 2 expired
    task automatic model_apply();
        bit rdy;
        rdy = (m_state != 1) && !ab;
        m_tc = 0;
        if (ab) begin
            m_state = 0;
            m_count = 0;
        end else if (lv && rdy) begin
            m_reload = lval;
            m_count = lval;
            m_state = (lval == 0) ? 2 : 1;
            m_tc = (lval == 0);
        end else if (m_state == 1 && en) begin
            if (m_count == 1) begin
                m_tc = 1;
                if (ar) m_count = m_reload;
                else begin
                    m_count = 0;
                    m_state = 2;
                end
            end else m_count = m_count - 1;
        end
    endtask

    task automatic step();
        model_apply();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        lv = 0; en = 0; ar = 0; ab = 0; lval = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        #12;
        total++; if (count_out !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        total++; if ({busy, done, tc_pulse} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, tc_pulse}); end
        @(negedge clock);
        resetn = 1;
        m_state = 0; m_count = 0; m_reload = 0; m_tc = 0;
        step();
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        total++; if (count_out !== 8'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle count=%0d busy=%b exp 0/0", count_out, busy); end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_c [6] = '{5, 4, 3, 2, 1, 0};
        idle_inputs();
        lv = 1; lval = 5; en = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            lv = 0;
            total++; if (count_out !== exp_c[i]) begin bad++; $display("FAIL oneshot_count[%0d] got=%0d exp=%0d", i, count_out, exp_c[i]); end
            total++; if (tc_pulse !== (i == 5)) begin bad++; $display("FAIL oneshot_tc[%0d] got=%b exp=%b", i, tc_pulse, i == 5); end
        end
        total++; if ({done, busy, load_ready} !== 3'b101) begin bad++; $display("FAIL oneshot_end done/busy/ready got=%b exp=101", {done, busy, load_ready}); end
        step();
        total++; if (tc_pulse !== 1'b0 || count_out !== 8'd0) begin bad++; $display("FAIL oneshot_hold tc=%b count=%0d exp 0/0", tc_pulse, count_out); end
    endtask

    task automatic test_periodic();
        idle_inputs();
        lv = 1; lval = 3; en = 1; ar = 1;
        step();
        lv = 0;
        total++; if (count_out !== 8'd3) begin bad++; $display("FAIL periodic_load got=%0d exp=3", count_out); end
        for (int k = 1; k <= 10; k++) begin
            step();
            total++; if (count_out !== 8'(3 - k % 3)) begin bad++; $display("FAIL periodic_count[%0d] got=%0d exp=%0d", k, count_out, 3 - k % 3); end
            total++; if (tc_pulse !== (k % 3 == 0)) begin bad++; $display("FAIL periodic_tc[%0d] got=%b exp=%b", k, tc_pulse, k % 3 == 0); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL periodic_busy[%0d] got=%b exp=1", k, busy); end
        end
        ab = 1;
        step();
        ab = 0;
    endtask

    task automatic test_enable_gating();
        logic       pat [6] = '{1, 0, 0, 1, 1, 1};
        logic [7:0] exp_c [6] = '{3, 3, 3, 2, 1, 0};
        idle_inputs();
        lv = 1; lval = 4;
        step();
        lv = 0;
        total++; if (count_out !== 8'd4) begin bad++; $display("FAIL gate_load got=%0d exp=4", count_out); end
        for (int i = 0; i < 6; i++) begin
            en = pat[i];
            step();
            total++; if (count_out !== exp_c[i]) begin bad++; $display("FAIL gate_count[%0d] got=%0d exp=%0d", i, count_out, exp_c[i]); end
            total++; if (tc_pulse !== (i == 5)) begin bad++; $display("FAIL gate_tc[%0d] got=%b exp=%b", i, tc_pulse, i == 5); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL gate_done got=%b exp=1", done); end
    endtask

    task automatic test_zero_load();
        idle_inputs();
        lv = 1; lval = 0; en = 1;
        step();
        lv = 0;
        total++; if ({done, busy, tc_pulse} !== 3'b101 || count_out !== 8'd0) begin bad++; $display("FAIL zero_load done/busy/tc=%b count=%0d exp 101/0", {done, busy, tc_pulse}, count_out); end
        step();
        total++; if ({done, busy, tc_pulse} !== 3'b100) begin bad++; $display("FAIL zero_after done/busy/tc=%b exp=100", {done, busy, tc_pulse}); end
    endtask

    task automatic test_abort();
        idle_inputs();
        lv = 1; lval = 2; en = 1;
        step();
        lv = 0;
        step();
        total++; if (count_out !== 8'd1) begin bad++; $display("FAIL abort_setup got=%0d exp=1", count_out); end
        ab = 1;
        step();
        ab = 0;
        total++; if ({busy, done, tc_pulse} !== 3'b000 || count_out !== 8'd0) begin bad++; $display("FAIL abort_run flags=%b count=%0d exp 000/0", {busy, done, tc_pulse}, count_out); end
        lv = 1; lval = 0;
        step();
        lv = 0;
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done_setup got=%b exp=1", done); end
        ab = 1; lv = 1; lval = 9;
        #1;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", load_ready); end
        step();
        idle_inputs();
        total++; if ({busy, done, tc_pulse} !== 3'b000 || count_out !== 8'd0) begin bad++; $display("FAIL abort_load flags=%b count=%0d exp 000/0", {busy, done, tc_pulse}, count_out); end
    endtask

    task automatic test_reset_mid_run();
        idle_inputs();
        lv = 1; lval = 10; en = 1;
        step();
        lv = 0;
        for (int i = 0; i < 3; i++) step();
        total++; if (count_out !== 8'd7) begin bad++; $display("FAIL midreset_setup got=%0d exp=7", count_out); end
        #2;
        resetn = 0;
        #1;
        total++; if (count_out !== 8'd0 || {busy, done, tc_pulse} !== 3'b000) begin bad++; $display("FAIL midreset_async count=%0d flags=%b exp 0/000", count_out, {busy, done, tc_pulse}); end
        m_state = 0; m_count = 0; m_reload = 0; m_tc = 0;
        @(negedge clock);
        resetn = 1;
        en = 0;
        step();
        total++; if ({busy, done, load_ready} !== 3'b001 || count_out !== 8'd0) begin bad++; $display("FAIL midreset_release busy/done/ready=%b count=%0d exp 001/0", {busy, done, load_ready}, count_out); end
    endtask

    task automatic test_random();
        int sel;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            lval = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'd255 : 8'($urandom_range(1, 12));
            lv = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 3) != 0);
            ar = $urandom_range(0, 1) == 1;
            ab = ($urandom_range(0, 24) == 0);
            #1;
            total++; if (load_ready !== ((m_state != 1) && !ab)) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, load_ready, (m_state != 1) && !ab); end
            step();
            total++; if (count_out !== m_count) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, count_out, m_count); end
            total++; if (tc_pulse !== m_tc) begin bad++; $display("FAIL rand_tc[%0d] got=%b exp=%b", n, tc_pulse, m_tc); end
            total++; if ({busy, done} !== {m_state == 1, m_state == 2}) begin bad++; $display("FAIL rand_state[%0d] busy/done=%b exp state=%0d", n, {busy, done}, m_state); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_enable_gating();
        test_zero_load();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer. It is the consuming counterpart to the free-running up counter.
- A value is loaded through a valid/ready handshake.
- The block counts down on enabled cycles and emits a one-cycle terminal-count pulse.
- It then either stops (one-shot) or reloads (periodic).
- It sits beside the up counter in the training datapath, where it generates timeouts and periodic ticks.

Parameters:
WIDTH, 8, width of load value and count output

Ports:
clock  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
load_valid  input  1  load request; load_value is valid while high
load_value  input  WIDTH  start/reload value
load_ready  output  1  block can accept a load this cycle (combinational)
enable  input  1  count enable; low holds count
auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at terminal edge
abort  input  1  synchronous stop/clear, highest priority after reset
count_out  output  WIDTH  current count (registered)
busy  output  1  high in RUN
done  output  1  high in DONE
tc_pulse  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Reset (resetn=0, async): state=IDLE, count_out=0, reload register=0, tc_pulse=0, busy=0, done=0.
- States: IDLE, RUN, DONE. Outputs decode from state: busy=(RUN), done=(DONE).
- load_ready = (state != RUN) && !abort. A load is accepted on an edge where load_valid && load_ready.
- Priority per edge: abort > load > count.
- Abort:
  - Any state -> IDLE, count_out=0, tc_pulse=0.
  - A load presented in the same cycle is not accepted.
  - A terminal count occurring in the same cycle is suppressed.
- Load accepted in IDLE/DONE with V = load_value:
  - Reload register = V.
  - If V != 0: count_out = V, state = RUN, tc_pulse = 0.
  - If V == 0: count_out = 0, state = DONE, tc_pulse = 1 for the next cycle (terminal count reached at acceptance).
- RUN, enable=0: count_out and state hold; tc_pulse=0.
- RUN, enable=1, count_out > 1: count_out decrements by 1.
- RUN, enable=1, count_out == 1 (terminal edge): tc_pulse=1 for exactly one cycle, then:
  - auto_reload=1: count_out = reload register; state stays RUN. Period = V enabled cycles.
  - auto_reload=0: count_out = 0; state = DONE.
- tc_pulse is 0 on every edge that is not a terminal edge or a zero-load acceptance.
- DONE: count_out holds 0; done=1. A new load restarts the timer. Abort returns to IDLE.
- IDLE: count_out=0. enable and auto_reload are ignored.
- Arithmetic: unsigned, WIDTH bits. Count never wraps below 0; terminal detection occurs at 1.
- Max load of 2^WIDTH-1 gives a 255-cycle period at WIDTH=8.
- load_value is captured only at acceptance. Changes while in RUN have no effect.
- Reset mid-operation: immediate return to reset values regardless of clock.

Test Plan:
- Reset, then load V=5 with enable=1 and auto_reload=0:
  - count_out goes 5,4,3,2,1,0 on successive edges.
  - tc_pulse is high exactly in the cycle count_out first reads 0.
  - done=1 afterwards; busy=0; load_ready=1.
- Load V=3 with auto_reload=1 and enable=1 for 10 edges:
  - count_out goes 3,2,1,3,2,1,3,...
  - tc_pulse is high once every 3 cycles, aligned with each reload to 3.
- Load V=4, enable toggling 1,0,0,1,1,1:
  - count_out holds during enable=0.
  - tc_pulse occurs only after the 4th enabled edge.
- Load V=0:
  - State goes directly to DONE, count_out=0.
  - tc_pulse is high for one cycle; busy never asserts.
- Abort:
  - Abort in RUN at count_out=1 together with enable=1 -> IDLE, count_out=0, no tc_pulse.
  - Abort with load_valid in DONE -> load_ready=0, no load accepted, state IDLE.
- Reset mid-run:
  - Assert resetn=0 asynchronously between edges at count_out=7 of a 10 load.
  - All outputs go to 0 immediately; after release, state is IDLE and load_ready=1.
